axi4_rd_rr_arbiter: RTL
=======================

// Module: axi4_rd_rr_arbiter
// PURPOSE
// Round-robin arbiter that shares one AXI4 read port (AR/R) of the memory slave between IFU and LSU.
// Grant is held from AR acceptance until the R handshake with rlast, so INCR bursts are never interleaved.
// A per-burst beat checker flags rlast/arlen mismatches.
// LSU AW/W/B traffic bypasses this block and goes straight to the slave.
// PARAMETERS
// DATA_WIDTH  32  R data width
// ADDR_WIDTH  32  AR address width
// ID_WIDTH    4   arid/rid width
// RR_ENABLE   1   1 = round-robin; 0 = fixed priority, IFU always wins
// PORTS  (M = ifu or lsu; all M_* ports are duplicated for each master)
// clk            in   1           single clock, rising edge
// rst            in   1           asynchronous, active-low reset
// M_arvalid      in   1           read request from master M
// M_araddr       in   ADDR_WIDTH  read address
// M_arid         in   ID_WIDTH    transaction ID
// M_arlen        in   8           burst length, beats-1
// M_arsize       in   3           beat size
// M_arburst      in   2           burst type
// M_arready      out  1           AR accepted for M
// M_rvalid       out  1           R beat for M
// M_rdata        out  DATA_WIDTH  read data, zero when M not granted
// M_rresp        out  2           response
// M_rlast        out  1           last beat
// M_rid          out  ID_WIDTH    response ID
// M_rready       in   1           M accepts R beat
// arvalid/araddr/arid/arlen/arsize/arburst  out  slave AR channel, same widths
// arready        in   1           slave accepts AR
// rvalid/rdata/rresp/rlast/rid  in  slave R channel, same widths
// rready         out  1           forwarded rready of granted master
// grant          out  2           00 none, 01 ifu, 10 lsu (debug/perf)
// err_burst      out  1           1-cycle pulse on a beat-count mismatch
// BEHAVIOUR
// Reset (rst=0, async): state=IDLE, grant=00, last_grant=LSU so IFU wins first; every output is 0.
// FSM IDLE:
// - No arvalid: stay.
// - Exactly one arvalid: grant that master, go ADDR.
// - Both arvalid: grant the master != last_grant (RR_ENABLE=0: IFU).
// - The grant register updates at the clock edge; slave arvalid rises one cycle after the master's arvalid.
// FSM ADDR:
// - Slave AR signals = granted master's AR signals; M_arready = arready.
// - On arvalid&&arready: latch arlen into len_q, clear beat_cnt, go DATA.
// - Granted master drops arvalid before acceptance (protocol violation): return to IDLE, grant=00, last_grant unchanged.
// FSM DATA:
// - Slave AR outputs are 0.
// - R is routed to the granted master; rready = granted M_rready.
// - Each rvalid&&rready increments beat_cnt (8-bit, wraps).
// - Handshake with rlast=1: go IDLE, last_grant <= grant, grant <= 00.
// - The next request therefore sees AR one cycle after IDLE is re-entered; there is no back-to-back grant.
// Non-granted master: arready, rvalid, rdata, rresp, rlast and rid are all 0. Its request waits with no loss.
// err_burst pulses on the handshake cycle when either:
// - rlast=1 and beat_cnt!=len_q (short burst), or
// - rlast=0 and beat_cnt==len_q (over-long burst).
// The burst still ends only on rlast.
// A request arriving while busy (ADDR/DATA) is ignored until IDLE. Fairness: alternating grants when both masters request continuously.
// rvalid in IDLE/ADDR (stray beat): rready=0, beat is not forwarded, no error.
// Combinational paths run only from grant/state to outputs and from slave inputs through muxes; there is no comb path from arvalid to arready.
// STRUCTURE
// Shared package axi_pkg:
// - GRANT_NONE/IFU/LSU constants
// - FSM state encoding IDLE/ADDR/DATA
// - RESP_OKAY/EXOKAY/SLVERR/DECERR
// Sub-module axi_burst_checker(clk, rst, start, len, beat, last, err): holds len_q, beat_cnt and err_burst.
// Top level: FSM, RR pointer, AR/R muxes.
// TESTING
// 1. Reset: rst=0 mid-DATA -> next cycle all outputs 0, grant=00; after release, IFU request granted first.
// 2. Single IFU: araddr=0x8000_0000, arlen=0 -> 1 beat rdata=0xDEADBEEF rlast=1 -> ifu_rdata=0xDEADBEEF, lsu_rvalid=0, IDLE.
// 3. Both request every cycle, 4 transactions -> grant sequence ifu, lsu, ifu, lsu; RR_ENABLE=0 -> ifu x4 while ifu requests.
// 4. LSU burst arlen=3, slave gives 4 beats with rready stalls, rlast on beat 4 -> 4 beats in order, err_burst=0, IFU blocked until rlast.
// 5. arlen=3, slave asserts rlast on beat 2 -> err_burst pulse on that cycle; FSM back to IDLE.
// 6. Slave arready held 0 for 5 cycles -> granted master's arvalid/araddr stable, grant unchanged, other master's arready=0.

Source files
------------

// File: rtl/axi4_rd_rr_arbiter_pkg.sv
// Shared definitions for the AXI4 read-port arbiter: grant codes, FSM states,
// response codes and the arbitration pick function.
package axi_pkg;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IFU  = 2'b01;
    localparam logic [1:0] GRANT_LSU  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // On contention the master that did not win last time goes next (fixed mode: IFU).
    function automatic logic [1:0] rr_pick(input logic       ifu_req,
                                           input logic       lsu_req,
                                           input logic [1:0] last_grant,
                                           input logic       rr_en);
        if (ifu_req && lsu_req)
            return (rr_en && (last_grant == GRANT_IFU)) ? GRANT_LSU : GRANT_IFU;
        else if (ifu_req)
            return GRANT_IFU;
        else if (lsu_req)
            return GRANT_LSU;
        else
            return GRANT_NONE;
    endfunction

endpackage

// File: rtl/axi4_rd_rr_arbiter_burst_checker.sv
// Per-burst beat counter; flags a handshake whose rlast disagrees with the
// burst length captured at AR acceptance.
module axi_burst_checker
    import axi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_len,
    input  logic       i_beat,
    input  logic       i_last,
    output logic       o_err
);

    logic [7:0] r_len_q;
    logic [7:0] r_beat_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len_q    <= 8'd0;
            r_beat_cnt <= 8'd0;
        end else if (i_start) begin
            r_len_q    <= i_len;
            r_beat_cnt <= 8'd0;
        end else if (i_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    // Short burst: rlast early. Over-long burst: no rlast on the final counted beat.
    assign o_err = i_beat && (i_last ? (r_beat_cnt != r_len_q) : (r_beat_cnt == r_len_q));

endmodule

// File: rtl/axi4_rd_rr_arbiter.sv
// Shares one AXI4 read port between IFU and LSU; the grant is held from AR
// acceptance to the rlast handshake so bursts never interleave.
//   state   | meaning
//   IDLE    | no grant, choose next master from pending arvalids
//   ADDR    | granted master's AR forwarded to slave, waiting for arready
//   DATA    | R beats routed to granted master until rlast handshake
module axi4_rd_rr_arbiter
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int RR_ENABLE  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ifu_arvalid,
    input  logic [ADDR_WIDTH-1:0] i_ifu_araddr,
    input  logic [ID_WIDTH-1:0]   i_ifu_arid,
    input  logic [7:0]            i_ifu_arlen,
    input  logic [2:0]            i_ifu_arsize,
    input  logic [1:0]            i_ifu_arburst,
    output logic                  o_ifu_arready,
    output logic                  o_ifu_rvalid,
    output logic [DATA_WIDTH-1:0] o_ifu_rdata,
    output logic [1:0]            o_ifu_rresp,
    output logic                  o_ifu_rlast,
    output logic [ID_WIDTH-1:0]   o_ifu_rid,
    input  logic                  i_ifu_rready,
    input  logic                  i_lsu_arvalid,
    input  logic [ADDR_WIDTH-1:0] i_lsu_araddr,
    input  logic [ID_WIDTH-1:0]   i_lsu_arid,
    input  logic [7:0]            i_lsu_arlen,
    input  logic [2:0]            i_lsu_arsize,
    input  logic [1:0]            i_lsu_arburst,
    output logic                  o_lsu_arready,
    output logic                  o_lsu_rvalid,
    output logic [DATA_WIDTH-1:0] o_lsu_rdata,
    output logic [1:0]            o_lsu_rresp,
    output logic                  o_lsu_rlast,
    output logic [ID_WIDTH-1:0]   o_lsu_rid,
    input  logic                  i_lsu_rready,
    output logic                  o_arvalid,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic [ID_WIDTH-1:0]   o_arid,
    output logic [7:0]            o_arlen,
    output logic [2:0]            o_arsize,
    output logic [1:0]            o_arburst,
    input  logic                  i_arready,
    input  logic                  i_rvalid,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rlast,
    input  logic [ID_WIDTH-1:0]   i_rid,
    output logic                  o_rready,
    output logic [1:0]            o_grant,
    output logic                  o_err_burst
);

    localparam logic W_RR_EN = (RR_ENABLE != 0);

    state_e     r_state, w_state_nxt;
    logic [1:0] r_grant, w_grant_nxt;
    logic [1:0] r_last_grant, w_last_grant_nxt;

    logic w_sel_ifu, w_sel_lsu, w_m_arvalid, w_m_rready, w_ar_hs, w_r_hs;

    assign w_sel_ifu   = (r_grant == GRANT_IFU);
    assign w_sel_lsu   = (r_grant == GRANT_LSU);
    assign w_m_arvalid = (w_sel_ifu && i_ifu_arvalid) || (w_sel_lsu && i_lsu_arvalid);
    assign w_m_rready  = (w_sel_ifu && i_ifu_rready) || (w_sel_lsu && i_lsu_rready);
    assign w_ar_hs     = (r_state == ST_ADDR) && w_m_arvalid && i_arready;
    assign w_r_hs      = (r_state == ST_DATA) && i_rvalid && w_m_rready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= GRANT_NONE;
            r_last_grant <= GRANT_LSU;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        unique case (r_state)
            ST_IDLE: begin
                w_grant_nxt = rr_pick(i_ifu_arvalid, i_lsu_arvalid, r_last_grant, W_RR_EN);
                if (w_grant_nxt != GRANT_NONE)
                    w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                // A master withdrawing its request releases the port without counting as a turn.
                if (!w_m_arvalid) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = GRANT_NONE;
                end else if (i_arready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_r_hs && i_rlast) begin
                    w_state_nxt      = ST_IDLE;
                    w_grant_nxt      = GRANT_NONE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = GRANT_NONE;
            end
        endcase
    end

    always_comb begin
        o_arvalid     = 1'b0;
        o_araddr      = '0;
        o_arid        = '0;
        o_arlen       = '0;
        o_arsize      = '0;
        o_arburst     = '0;
        o_ifu_arready = 1'b0;
        o_lsu_arready = 1'b0;
        o_rready      = 1'b0;
        o_ifu_rvalid  = 1'b0;
        o_ifu_rdata   = '0;
        o_ifu_rresp   = '0;
        o_ifu_rlast   = 1'b0;
        o_ifu_rid     = '0;
        o_lsu_rvalid  = 1'b0;
        o_lsu_rdata   = '0;
        o_lsu_rresp   = '0;
        o_lsu_rlast   = 1'b0;
        o_lsu_rid     = '0;
        if (r_state == ST_ADDR) begin
            o_arvalid     = w_m_arvalid;
            o_araddr      = w_sel_ifu ? i_ifu_araddr  : i_lsu_araddr;
            o_arid        = w_sel_ifu ? i_ifu_arid    : i_lsu_arid;
            o_arlen       = w_sel_ifu ? i_ifu_arlen   : i_lsu_arlen;
            o_arsize      = w_sel_ifu ? i_ifu_arsize  : i_lsu_arsize;
            o_arburst     = w_sel_ifu ? i_ifu_arburst : i_lsu_arburst;
            o_ifu_arready = w_sel_ifu && i_arready;
            o_lsu_arready = w_sel_lsu && i_arready;
        end
        if (r_state == ST_DATA) begin
            o_rready = w_m_rready;
            if (w_sel_ifu) begin
                o_ifu_rvalid = i_rvalid;
                o_ifu_rdata  = i_rdata;
                o_ifu_rresp  = i_rresp;
                o_ifu_rlast  = i_rlast;
                o_ifu_rid    = i_rid;
            end
            if (w_sel_lsu) begin
                o_lsu_rvalid = i_rvalid;
                o_lsu_rdata  = i_rdata;
                o_lsu_rresp  = i_rresp;
                o_lsu_rlast  = i_rlast;
                o_lsu_rid    = i_rid;
            end
        end
    end

    assign o_grant = r_grant;

    axi_burst_checker u_burst_checker (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_ar_hs),
        .i_len   (o_arlen),
        .i_beat  (w_r_hs),
        .i_last  (i_rlast),
        .o_err   (o_err_burst)
    );

endmodule
